ctrl_pc_sequencer: RTL and testbench
====================================

# ctrl_pc_sequencer

Program-counter and control-flow sequencer that sits directly upstream of the 8-entry call/return stack. It owns the 10-bit PC and resolves JMP, JMP{LT,GT,EQ,C} and JR RA each cycle. It drives the stack's push/pop/push_addr and consumes its ret_addr/empty. Because the stack's ret_addr lags its pointer, the sequencer enforces a settle interlock before any JR RA.

## Interface
- ADDR_W, 10, PC / return-address width
- STACK_USABLE, 7, entries the stack accepts before ignoring pushes
- SETTLE, 2, cycles after a push/pop before ret_addr is valid
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr_valid  in  1  decoded instruction present this cycle
- stall_in  in  1  downstream stall; freezes all state
- is_jmp  in  1  unconditional jump
- is_jcond  in  1  conditional jump
- cond_sel  in  2  00 LT, 01 GT, 10 EQ, 11 C
- flag_lt, flag_gt, flag_eq, flag_c  in  1 each  ALU flags
- is_jr_ra  in  1  return via stack top
- target  in  ADDR_W  jump target
- ret_addr  in  ADDR_W  stack top, from call/return stack
- stack_empty  in  1  from call/return stack
- pc  out  ADDR_W  current PC, registered
- push  out  1  stack push strobe
- pop  out  1  stack pop strobe
- push_addr  out  ADDR_W  return address (pc+1, wraps)
- hold  out  1  fetch must re-present the same instruction
- redirect  out  1  PC will leave sequential flow at next edge (flush fetch)
- overflow  out  1  sticky: push attempted at full depth
- underflow  out  1  sticky: JR RA with empty stack

## Operation
- "Advance" = instr_valid & !stall_in & !hold & !reset. State changes only on advance, except settle_cnt decrements whenever !stall_in.
- Decode priority: is_jr_ra > is_jmp > is_jcond; multiple asserted is treated per priority.
- Taken: is_jmp, or is_jcond with selected flag = 1.
- Taken jump: pc <= target; push=1, push_addr=pc+1 (1023 -> 0). If depth == STACK_USABLE: push still issued (stack ignores it), depth unchanged, overflow <= 1.
- JR RA, stack non-empty: pc <= ret_addr; pop=1; depth decrements.
- JR RA, stack_empty: pc <= 0, no pop, underflow <= 1.
- Otherwise: pc <= pc+1 mod 1024.
- Internal depth counter 0..STACK_USABLE tracks stack occupancy.
- settle_cnt loads SETTLE on any push or pop issued. hold = instr_valid & is_jr_ra & settle_cnt != 0 (combinational). While hold: no pop, pc frozen.
- push/pop/redirect are combinational, gated by advance; never asserted during reset or stall_in.
- overflow/underflow clear only on reset.

## Timing
- Reset: pc=0, depth=0, settle_cnt=0, overflow=0, underflow=0; push=pop=redirect=hold=0.
- Reset mid-operation: all state returns to reset values at that edge, regardless of pending hold.
- pc updates at the edge where advance is high; push/pop sampled by the stack at that same edge.
- Stack ret_addr valid SETTLE cycles after the push/pop edge; JR RA issued one cycle after a call holds for 2 cycles and pops on the 3rd.
- JR RA with no preceding push/pop in the last 2 cycles: zero-cycle hold.
- stall_in high: pc, depth, flags and settle_cnt frozen; strobes low.

## Test plan
- Reset then 5 valid NOPs -> pc 0,1,2,3,4,5; no strobes.
- pc=0x010, JMP target 0x200 -> push=1, push_addr=0x011, redirect=1, pc=0x200; next cycle JR RA -> hold 2 cycles, then pop=1, pc=0x011.
- pc=0x020, JMPEQ 0x300 with flag_eq=0 -> pc=0x021, no push; with flag_eq=1 -> pc=0x300, push_addr=0x021.
- 8 taken jumps with no returns -> overflow=1 after the 8th, depth stays 7; reset -> overflow=0, pc=0.
- JR RA at reset (stack_empty=1) -> pc=0, pop=0, underflow=1.
- pc=0x3FF, taken JMP 0x005 -> push_addr=0x000; stall_in during a held JR RA -> settle_cnt frozen, no pop.

Source files
------------

// File: rtl/ctrl_pc_sequencer_if.sv
// ctrl_pc_sequencer_if: decode/flag inputs, call-stack handshake and PC outputs of the sequencer
interface ctrl_pc_sequencer_if #(parameter int ADDR_W = 10);
  logic              instr_valid, stall_in, is_jmp, is_jcond, is_jr_ra;
  logic [1:0]        cond_sel;
  logic              flag_lt, flag_gt, flag_eq, flag_c;
  logic [ADDR_W-1:0] target, ret_addr, pc, push_addr;
  logic              stack_empty, push, pop, hold, redirect, overflow, underflow;
  modport master (
    output instr_valid, stall_in, is_jmp, is_jcond, is_jr_ra, cond_sel,
           flag_lt, flag_gt, flag_eq, flag_c, target, ret_addr, stack_empty,
    input  pc, push, pop, push_addr, hold, redirect, overflow, underflow
  );
  modport slave (
    input  instr_valid, stall_in, is_jmp, is_jcond, is_jr_ra, cond_sel,
           flag_lt, flag_gt, flag_eq, flag_c, target, ret_addr, stack_empty,
    output pc, push, pop, push_addr, hold, redirect, overflow, underflow
  );
endinterface

// File: rtl/ctrl_pc_sequencer.sv
// ctrl_pc_sequencer: PC owner resolving jumps/returns against a lagging call/return stack
module ctrl_pc_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int STACK_USABLE = 7,
  parameter int SETTLE       = 2
) (
  input logic               clk,
  input logic               reset,
  ctrl_pc_sequencer_if.slave bus
);
  localparam int DW = $clog2(STACK_USABLE + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_USABLE);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [DW-1:0]     depth_q, depth_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              flag_sel, taken, hold, adv, push, pop;
  assign bus.pc        = pc_q;
  assign bus.push_addr = pc_inc;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.push      = push;
  assign bus.pop       = pop;
  assign bus.hold      = hold;
  // decode, settle interlock, strobes and next state; a return outranks any jump
  always_comb begin
    flag_sel = bus.cond_sel[1] ? (bus.cond_sel[0] ? bus.flag_c : bus.flag_eq)
                               : (bus.cond_sel[0] ? bus.flag_gt : bus.flag_lt);
    taken    = !bus.is_jr_ra & (bus.is_jmp | (bus.is_jcond & flag_sel));
    hold     = !reset & bus.instr_valid & bus.is_jr_ra & (settle_q != '0);
    adv      = bus.instr_valid & !bus.stall_in & !hold & !reset;
    push     = adv & taken;
    pop      = adv & bus.is_jr_ra & !bus.stack_empty;
    bus.redirect = adv & (taken | bus.is_jr_ra);
    pc_inc   = pc_q + ADDR_W'(1);
    pc_d     = !adv ? pc_q
             : bus.is_jr_ra ? (bus.stack_empty ? '0 : bus.ret_addr)
             : taken ? bus.target : pc_inc;
    depth_d  = (push & (depth_q != DEPTH_MAX)) ? depth_q + DW'(1)
             : (pop & (depth_q != '0)) ? depth_q - DW'(1) : depth_q;
    ovf_d    = ovf_q | (push & (depth_q == DEPTH_MAX));
    unf_d    = unf_q | (adv & bus.is_jr_ra & bus.stack_empty);
    settle_d = bus.stall_in ? settle_q
             : (push | pop) ? SETTLE_LD
             : (settle_q != '0) ? settle_q - SW'(1) : settle_q;
  end
  // state registers; reset overrides any pending hold
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      depth_q  <= '0;
      settle_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      depth_q  <= depth_d;
      settle_q <= settle_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
endmodule

// File: tb/tb_ctrl_pc_sequencer.sv
// tb_ctrl_pc_sequencer: directed stimulus with a cycle model of sequencer and call/return stack
module tb_ctrl_pc_sequencer;
  localparam int AW = 10, USABLE = 7, SET = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0, checks = 0;
  bit   started = 1'b0;
  int   m_pc = 0, m_depth = 0, m_ucyc = 0, m_last = -100;
  bit   m_ovf = 1'b0, m_unf = 1'b0;
  int   stk[8];
  int   sp = 0, r0 = 0, r1 = 0;

  ctrl_pc_sequencer_if #(.ADDR_W(AW)) bus();
  ctrl_pc_sequencer #(.ADDR_W(AW), .STACK_USABLE(USABLE), .SETTLE(SET)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic jmp, input logic jc, input logic jr,
                       input logic [1:0] sel, input logic [AW-1:0] tgt);
    bus.instr_valid = iv;
    bus.is_jmp      = jmp;
    bus.is_jcond    = jc;
    bus.is_jr_ra    = jr;
    bus.cond_sel    = sel;
    bus.target      = tgt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // behavioural model: compare every cycle, then advance model and stack contents
  always @(negedge clk) if (started) begin
    logic [3:0] f;
    bit jr, tk, hd, adv, ps, pp;
    int pa;
    f   = {bus.flag_c, bus.flag_eq, bus.flag_gt, bus.flag_lt};
    jr  = bus.is_jr_ra;
    tk  = !jr && (bus.is_jmp || (bus.is_jcond && f[bus.cond_sel]));
    hd  = !reset && bus.instr_valid && jr && (m_ucyc - m_last < SET);
    adv = bus.instr_valid && !bus.stall_in && !hd && !reset;
    ps  = adv && tk;
    pp  = adv && jr && !bus.stack_empty;
    pa  = (m_pc + 1) % 1024;
    chk("m_pc", bus.pc, m_pc);
    chk("m_push", bus.push, ps);
    chk("m_pop", bus.pop, pp);
    chk("m_hold", bus.hold, hd);
    chk("m_redirect", bus.redirect, adv && (tk || jr));
    chk("m_overflow", bus.overflow, m_ovf);
    chk("m_underflow", bus.underflow, m_unf);
    chk("m_depth", dut.depth_q, m_depth);
    if (ps) chk("m_push_addr", bus.push_addr, pa);
    if (reset) begin
      m_pc = 0; m_depth = 0; m_ucyc = 0; m_last = -100; m_ovf = 0; m_unf = 0; sp = 0;
    end else begin
      if (!bus.stall_in) m_ucyc++;
      if (ps || pp) m_last = m_ucyc;
      if (ps && sp < USABLE) begin stk[sp] = pa; sp++; end
      if (pp && sp > 0) sp--;
      if (adv) begin
        if (jr) begin
          if (bus.stack_empty) begin m_pc = 0; m_unf = 1; end
          else begin m_pc = int'(bus.ret_addr); if (m_depth > 0) m_depth--; end
        end else if (tk) begin
          m_pc = int'(bus.target);
          if (m_depth == USABLE) m_ovf = 1; else m_depth++;
        end else m_pc = pa;
      end
    end
  end

  // stack outputs: ret_addr shows the top as it was SETTLE edges ago
  always @(posedge clk) begin
    #1;
    bus.ret_addr    = AW'(r1);
    r1              = r0;
    r0              = (sp > 0) ? stk[sp-1] : 0;
    bus.stack_empty = (sp == 0);
  end

  initial begin
    drive(0, 0, 0, 0, 2'd0, '0);
    bus.stall_in = 0; bus.flag_lt = 0; bus.flag_gt = 0; bus.flag_eq = 0; bus.flag_c = 0;
    bus.ret_addr = '0; bus.stack_empty = 1;
    tick;
    started = 1;
    tick;
    @(negedge clk);
    chk("rst_pc", bus.pc, 0);
    chk("rst_strobes", {bus.push, bus.pop, bus.redirect, bus.hold}, 0);
    tick;
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 0, 2'd0, '0);
      @(negedge clk);
      if (i <= 5) chk("nop_pc", bus.pc, i);
      if (i <= 5) chk("nop_push", bus.push, 0);
      tick;
    end
    drive(1, 1, 0, 0, 2'd0, 10'h200);
    @(negedge clk);
    chk("call_push", bus.push, 1);
    chk("call_push_addr", bus.push_addr, 'h011);
    chk("call_redirect", bus.redirect, 1);
    tick;
    drive(1, 0, 0, 1, 2'd0, '0);
    @(negedge clk);
    chk("ret_pc_target", bus.pc, 'h200);
    chk("ret_hold1", bus.hold, 1);
    tick;
    @(negedge clk);
    chk("ret_hold2", bus.hold, 1);
    chk("ret_nopop2", bus.pop, 0);
    tick;
    @(negedge clk);
    chk("ret_hold3", bus.hold, 0);
    chk("ret_pop3", bus.pop, 1);
    tick;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 0, 2'd0, '0);
      @(negedge clk);
      if (i == 0) chk("ret_pc", bus.pc, 'h011);
      tick;
    end
    drive(1, 0, 1, 0, 2'd2, 10'h300);
    bus.flag_eq = 0;
    @(negedge clk);
    chk("jeq0_pc", bus.pc, 'h020);
    chk("jeq0_push", bus.push, 0);
    chk("jeq0_redirect", bus.redirect, 0);
    tick;
    drive(1, 1, 0, 0, 2'd0, 10'h020);
    @(negedge clk);
    chk("jeq0_next_pc", bus.pc, 'h021);
    tick;
    drive(1, 0, 1, 0, 2'd2, 10'h300);
    bus.flag_eq = 1;
    @(negedge clk);
    chk("jeq1_push", bus.push, 1);
    chk("jeq1_push_addr", bus.push_addr, 'h021);
    tick;
    bus.flag_eq = 0;
    drive(0, 0, 0, 0, 2'd0, '0);
    @(negedge clk);
    chk("jeq1_pc", bus.pc, 'h300);
    reset = 1;
    tick;
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 2'd0, AW'(32'h40 + i));
      @(negedge clk);
      if (i == 7) chk("ovf_before8", bus.overflow, 0);
      tick;
    end
    drive(0, 0, 0, 0, 2'd0, '0);
    @(negedge clk);
    chk("ovf_after8", bus.overflow, 1);
    chk("ovf_depth", dut.depth_q, 7);
    chk("ovf_pc", bus.pc, 'h047);
    reset = 1;
    tick;
    reset = 0;
    @(negedge clk);
    chk("ovf_cleared", bus.overflow, 0);
    chk("ovf_rst_pc", bus.pc, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 2'd0, '0);
      tick;
    end
    drive(1, 0, 0, 1, 2'd0, '0);
    @(negedge clk);
    chk("unf_pc_before", bus.pc, 3);
    chk("unf_nohold", bus.hold, 0);
    chk("unf_nopop", bus.pop, 0);
    tick;
    drive(0, 0, 0, 0, 2'd0, '0);
    @(negedge clk);
    chk("unf_pc", bus.pc, 0);
    chk("unf_flag", bus.underflow, 1);
    tick;
    drive(1, 1, 0, 0, 2'd0, 10'h3FF);
    tick;
    drive(1, 1, 0, 0, 2'd0, 10'h005);
    @(negedge clk);
    chk("wrap_pc", bus.pc, 'h3FF);
    chk("wrap_push_addr", bus.push_addr, 0);
    tick;
    drive(1, 0, 0, 1, 2'd0, '0);
    @(negedge clk);
    chk("stall_hold1", bus.hold, 1);
    tick;
    bus.stall_in = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_hold", bus.hold, 1);
      chk("stall_nopop", bus.pop, 0);
      tick;
    end
    bus.stall_in = 0;
    @(negedge clk);
    chk("stall_frozen_hold", bus.hold, 1);
    tick;
    @(negedge clk);
    chk("stall_pop", bus.pop, 1);
    tick;
    drive(0, 0, 0, 0, 2'd0, '0);
    @(negedge clk);
    chk("stall_ret_pc", bus.pc, 0);
    tick;
    drive(1, 1, 0, 0, 2'd0, 10'h123);
    tick;
    drive(1, 0, 0, 1, 2'd0, '0);
    reset = 1;
    @(negedge clk);
    chk("rst_hold_gated", bus.hold, 0);
    chk("rst_pop_gated", bus.pop, 0);
    tick;
    reset = 0;
    drive(0, 0, 0, 0, 2'd0, '0);
    @(negedge clk);
    chk("rst_mid_pc", bus.pc, 0);
    chk("rst_mid_flags", {bus.overflow, bus.underflow}, 0);
    tick;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
